// File: rtl/glyph_blit_ctrl.sv
// Glyph blitter: fetches a 10x10 bitmap from the glyph ROM and streams it to the
// framebuffer one row per accepted write, clipping rows that fall below the bottom edge.
module glyph_blit_ctrl #(
   parameter int GLYPH_W     = 10,
   parameter int GLYPH_H     = 10,
   parameter int GLYPH_COUNT = 10,
   parameter int X_W         = 8,
   parameter int Y_W         = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [31:0]                cmd_glyph,
   input  logic [X_W-1:0]             cmd_x,
   input  logic [Y_W-1:0]             cmd_y,
   output logic [31:0]                rom_addr,
   input  logic [GLYPH_W*GLYPH_H-1:0] rom_data,
   output logic                       fb_we,
   input  logic                       fb_ready,
   output logic [X_W-1:0]             fb_col,
   output logic [Y_W-1:0]             fb_row,
   output logic [GLYPH_W-1:0]         fb_bits,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int WORD_W = GLYPH_W * GLYPH_H;
   localparam int ROW_W  = $clog2(GLYPH_H + 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_H - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ROW,
      S_DONE,
      S_ERR
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [ROW_W-1:0]    r_row;
   logic [WORD_W-1:0]   r_glyph;
   logic [31:0]         r_rom_addr;

   logic                w_accept;
   logic                w_bad_idx;
   logic                w_wr_fire;
   logic [Y_W:0]        w_row_sum;
   logic                w_clip_next;
   logic                w_last_row;
   logic [WORD_W-1:0]   w_shifted;

   assign w_accept  = cmd_valid & cmd_ready;
   assign w_bad_idx = (cmd_glyph >= 32'(GLYPH_COUNT));
   assign w_wr_fire = fb_we & fb_ready;

   // Row sum carries one extra bit; once the current row is the bottom line every
   // later row is off-screen, so the command ends right after this write.
   assign w_row_sum   = {1'b0, r_y} + (Y_W+1)'(r_row);
   assign w_clip_next = (w_row_sum == {1'b0, {Y_W{1'b1}}});
   assign w_last_row  = (r_row == LAST_ROW) | w_clip_next;

   assign w_shifted = r_glyph << (GLYPH_W * r_row);
   assign fb_bits   = w_shifted[WORD_W-1 -: GLYPH_W];
   assign fb_row    = w_row_sum[Y_W-1:0];
   assign fb_col    = r_x;
   assign rom_addr  = r_rom_addr;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_bad_idx ? S_ERR : S_FETCH;
         S_FETCH: w_next = S_LATCH;
         S_LATCH: w_next = S_ROW;
         S_ROW:   if (w_wr_fire && w_last_row) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      fb_we     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_ROW:   fb_we = 1'b1;
         S_DONE:  done  = 1'b1;
         S_ERR:   err   = 1'b1;
         default: ;
      endcase
   end

   // NOTE: the 100-bit bitmap register is reset like any other flop so fb_bits reads
   // zero out of reset; it is a single register, not an addressable memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_row      <= '0;
         r_glyph    <= '0;
         r_rom_addr <= '0;
      end else begin
         if (w_accept) begin
            r_x   <= cmd_x;
            r_y   <= cmd_y;
            r_row <= '0;
            if (!w_bad_idx) r_rom_addr <= cmd_glyph;
         end
         if (r_state == S_LATCH) r_glyph <= rom_data;
         if (w_wr_fire && !w_last_row) r_row <= r_row + ROW_W'(1);
      end
   end

endmodule
